// File: rtl/digest_serializer.sv
// Output width converter: takes one DIGEST_BITS digest per load and hands it out
// MS word first as NUM_WORDS words on a valid/ack handshake with backpressure.
module digest_serializer #(
  parameter int DIGEST_BITS = 512,
  parameter int WORD_BITS   = 32,
  parameter int NUM_WORDS   = DIGEST_BITS / WORD_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DIGEST_BITS-1:0] in,
  input  logic                   in_ready,
  output logic                   in_ack,
  output logic                   busy,
  output logic [WORD_BITS-1:0]   out,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ack
);

  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [DIGEST_BITS-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]       count, count_nxt;
  logic                   in_ack_r, ack_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      count    <= '0;
      in_ack_r <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      count    <= count_nxt;
      in_ack_r <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    count_nxt = count;
    ack_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (in_ready) begin
          state_nxt = DRAIN;
          shreg_nxt = in;
          count_nxt = '0;
          ack_nxt   = 1'b1;
        end
      end
      DRAIN: begin
        if (out_ack) begin
          // Final word: drop back to IDLE with the register zeroed so out reads 0.
          if (count == LAST_IDX) begin
            state_nxt = IDLE;
            shreg_nxt = '0;
            count_nxt = '0;
          end else begin
            shreg_nxt = shreg << WORD_BITS;
            count_nxt = count + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ack    = in_ack_r;
  assign busy      = (state == DRAIN);
  assign out_valid = (state == DRAIN);
  assign out       = shreg[DIGEST_BITS-1 -: WORD_BITS];
  assign out_last  = (state == DRAIN) && (count == LAST_IDX);

endmodule

// File: doc/digest_serializer.md
Name: digest_serializer

Overview:
- Output-side width converter for the SHA3-512 core; the reverse of the input padder's word-to-block packing.
- Accepts one 512-bit digest from the permutation/finalisation stage in a single cycle.
- Emits the digest as 16 consecutive 32-bit words on a valid/ack handshake with backpressure.
- Sits between the f_permutation result register and the host/bus read port.

Parameters:
- DIGEST_BITS, 512, width of the digest accepted in one load.
- WORD_BITS, 32, width of each emitted word; DIGEST_BITS must be an integer multiple.
- NUM_WORDS, DIGEST_BITS/WORD_BITS (16), number of words per digest; counter width is clog2(NUM_WORDS).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in  input  DIGEST_BITS  digest; word 0 is in[511:480] (MS word first).
- in_ready  input  1  digest valid this cycle.
- in_ack  output  1  one-cycle pulse: digest latched at this edge.
- busy  output  1  high while holding an undrained digest; new digests refused.
- out  output  WORD_BITS  current word.
- out_valid  output  1  out holds a valid word.
- out_last  output  1  current word is word NUM_WORDS-1; qualified by out_valid.
- out_ack  input  1  consumer takes out this cycle when out_valid=1.

Behaviour:
- Reset (synchronous, sampled at clk edge) has priority over all other inputs. It clears the shift register to 0, the word counter to 0, and drives busy=0, out_valid=0, out_last=0, in_ack=0, out=0. Reset mid-stream abandons the remaining words; no partial word is emitted afterwards.
- States:
  - IDLE (busy=0, out_valid=0).
  - DRAIN (busy=1, out_valid=1).
- IDLE: in_ready=1 at an edge latches in into the shift register, sets count=0, and enters DRAIN. in_ack=1 for exactly the cycle after the edge; busy and out_valid are registered and go high in that same cycle. Load-to-first-word latency is 1 cycle.
- DRAIN: out = shift register [DIGEST_BITS-1 -: WORD_BITS]. out_last = (count==NUM_WORDS-1).
  - out_valid=1 and out_ack=1 at an edge: shift left by WORD_BITS, count+1.
  - On the handshake of word NUM_WORDS-1: return to IDLE, clear busy and out_valid, zero the register.
- out_ack=0: out, out_valid and out_last hold stable for any number of cycles.
- out_ack while out_valid=0: ignored.
- in_ready while busy=1 (including the cycle of the final handshake): ignored. No latch, no in_ack. The source must hold in_ready until it sees in_ack. The earliest new load is the edge after busy falls, so there is at least one idle cycle between digests.
- Full throughput with out_ack held high: 16 words on 16 consecutive cycles, then 1 idle cycle, then the next load.
- Simultaneous reset and in_ready: reset wins and nothing is latched.
- in is sampled only at the load edge; later changes have no effect.

Test Plan:
- Load in={16 words 0x00000000..0x0000000F, MS first} with out_ack tied 1:
  - in_ack pulses once.
  - out = 0x0,0x1,...,0xF on 16 consecutive cycles.
  - out_last=1 only on 0xF.
  - Then out_valid=0 and busy=0.
- Backpressure: same digest with out_ack alternating 0/1 (start 0) -> each word held stable for 2 cycles, order unchanged, 32 cycles total.
- Busy refusal: load digest A = {16{32'h12345678}}. Keep in_ready=1 with in = {16{32'h90ABCDEF}} throughout the drain -> no second in_ack during the drain. All 16 words equal 0x12345678. Digest B is latched the edge after busy falls and then emits 0x90ABCDEF x16.
- Reset mid-stream: reset for 1 cycle after the 5th handshake -> out_valid=0, busy=0, out=0 next cycle. No further words while in_ready=0 for 10 cycles. A new load then restarts at word 0.
- Stall before the first ack: load, then hold out_ack=0 for 20 cycles -> out stays at word 0 with out_valid=1 and out_last=0 throughout.
- Reset priority: assert reset and in_ready together -> no in_ack, busy stays 0.
